// File: rtl/l1_pkg.sv
// Shared definitions for the set_assoc_l1 cache: controller state encoding and
// byte-address field helpers (word, set and tag extraction).
package l1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } l1_state_e;

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int ibits, input int sbits);
        return addr >> (2 + ibits + sbits);
    endfunction

    function automatic logic [31:0] addr_set(input logic [31:0] addr, input int ibits, input int sbits);
        return (addr >> (2 + ibits)) & ((32'd1 << sbits) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] addr, input int ibits, input int sbits);
        return ((addr >> 2) & ((32'd1 << ibits) - 32'd1)) | (32'd0 & 32'(sbits));
    endfunction

endpackage

// File: rtl/l1_cache_way.sv
// One way of the L1: per-set valid bits, tag store and block data store.
// Lookup is combinational on the requested set/tag/word.
module l1_cache_way #(
    parameter int BSIZE = 8,
    parameter int NSETS = 256,
    parameter int IBITS = 3,
    parameter int SBITS = 8,
    parameter int TBITS = 19
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             inval,
    input  logic [SBITS-1:0] lookup_set,
    input  logic [TBITS-1:0] lookup_tag,
    input  logic [IBITS-1:0] lookup_word,
    input  logic             data_we,
    input  logic [IBITS-1:0] wr_word,
    input  logic [31:0]      wr_data,
    input  logic             tag_we,
    output logic             hit,
    output logic             valid,
    output logic [31:0]      rdata
);

    logic [NSETS-1:0] valid_r;
    logic [TBITS-1:0] tag_r  [NSETS];
    logic [31:0]      data_r [NSETS*BSIZE];

    // Valid bits: cleared by reset or flush, set when a refill completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r <= {NSETS{1'b0}};
        end else if (flush) begin
            valid_r <= {NSETS{1'b0}};
        end else if (tag_we) begin
            valid_r[lookup_set] <= 1'b1;
        end else if (inval) begin
            valid_r[lookup_set] <= 1'b0;
        end
    end

    // Tag and data storage carry no reset; only valid bits qualify them.
    always_ff @(posedge clock) begin
        if (tag_we) begin
            tag_r[lookup_set] <= lookup_tag;
        end
        if (data_we) begin
            data_r[{lookup_set, wr_word}] <= wr_data;
        end
    end

    assign valid = valid_r[lookup_set];
    assign hit   = valid_r[lookup_set] && (tag_r[lookup_set] == lookup_tag);
    assign rdata = data_r[{lookup_set, lookup_word}];

endmodule

// File: rtl/l1_checker.sv
// Protocol and structural checks for set_assoc_l1: single-way tag match and
// the processor holding its request while the cache talks to LL memory.
module l1_checker
    import l1_pkg::*;
#(
    parameter int WAYS = 2
) (
    input logic            clock,
    input logic            reset,
    input l1_state_e       state,
    input logic            enable,
    input logic [WAYS-1:0] hits
);

    a_single_hit: assert property (@(posedge clock) disable iff (reset) $onehot0(hits));

    a_req_held: assert property (@(posedge clock) disable iff (reset)
        ((state == REFILL) || (state == WRITE)) |-> enable);

endmodule

// File: rtl/set_assoc_l1.sv
// N-way set-associative write-through, no-write-allocate L1 with block refill,
// invalid-first/round-robin victim choice and one-cycle flush. Macro L1_STATS_EN adds hit/miss counters.
module set_assoc_l1
    import l1_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int BSIZE = 8,
    parameter int NSETS = 256
) (
    input  logic        clock,
    input  logic        reset,
`ifdef L1_STATS_EN
    output logic [31:0] hitCount,
    output logic [31:0] missCount,
`endif
    input  logic [31:0] addrFromProc,
    input  logic        enableFromProc,
    input  logic        writeFromProc,
    input  logic [31:0] dataFromProc,
    input  logic        flushFromProc,
    output logic [31:0] dataToProc,
    output logic        readyToProc,
    output logic [31:0] addrToLl,
    output logic        enableToLl,
    output logic        writeToLl,
    output logic [31:0] dataToLl,
    input  logic [31:0] dataFromLl,
    input  logic        readyFromLl
);

    localparam int IBITS = $clog2(BSIZE);
    localparam int SBITS = $clog2(NSETS);
    localparam int TBITS = 30 - IBITS - SBITS;
    localparam int WBITS = (WAYS > 1) ? $clog2(WAYS) : 1;

    l1_state_e                   state_r, state_s;
    logic [IBITS-1:0]            cnt_r;
    logic [WBITS-1:0]            victim_r, victim_s, hit_way_s;
    logic                        victim_valid_r, victim_valid_s;
    logic [NSETS-1:0][WBITS-1:0] rr_r;
    logic [31:0]                 data_r;

    logic [SBITS-1:0] req_set_s;
    logic [TBITS-1:0] req_tag_s;
    logic [IBITS-1:0] req_word_s;
    logic [WAYS-1:0]  hit_vec_s, valid_vec_s, data_we_s, tag_we_s, inval_s;
    logic [31:0]      rdata_s [WAYS];
    logic             hit_any_s, flush_s, last_beat_s, req_read_s;
    logic [31:0]      hit_data_s, wr_data_s;
    logic [IBITS-1:0] wr_word_s;

    assign req_set_s   = SBITS'(addr_set(addrFromProc, IBITS, SBITS));
    assign req_tag_s   = TBITS'(addr_tag(addrFromProc, IBITS, SBITS));
    assign req_word_s  = IBITS'(addr_word(addrFromProc, IBITS, SBITS));
    assign hit_any_s   = |hit_vec_s;
    assign last_beat_s = readyFromLl && (cnt_r == IBITS'(BSIZE - 1));
    assign req_read_s  = enableFromProc && !flushFromProc && !writeFromProc;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        l1_cache_way #(
            .BSIZE(BSIZE), .NSETS(NSETS), .IBITS(IBITS), .SBITS(SBITS), .TBITS(TBITS)
        ) u_way (
            .clock      (clock),
            .reset      (reset),
            .flush      (flush_s),
            .inval      (inval_s[w]),
            .lookup_set (req_set_s),
            .lookup_tag (req_tag_s),
            .lookup_word(req_word_s),
            .data_we    (data_we_s[w]),
            .wr_word    (wr_word_s),
            .wr_data    (wr_data_s),
            .tag_we     (tag_we_s[w]),
            .hit        (hit_vec_s[w]),
            .valid      (valid_vec_s[w]),
            .rdata      (rdata_s[w])
        );
    end

    l1_checker #(.WAYS(WAYS)) u_chk (
        .clock (clock),
        .reset (reset),
        .state (state_r),
        .enable(enableFromProc),
        .hits  (hit_vec_s)
    );

    // Hit data/way reduction (match is one-hot) and victim choice: lowest invalid way, else rr pointer.
    always_comb begin
        hit_way_s      = {WBITS{1'b0}};
        hit_data_s     = 32'd0;
        victim_s       = rr_r[req_set_s];
        victim_valid_s = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way_s      = hit_way_s | (WBITS'(w) & {WBITS{hit_vec_s[w]}});
            hit_data_s     = hit_data_s | (rdata_s[w] & {32{hit_vec_s[w]}});
            victim_s       = valid_vec_s[w] ? victim_s : WBITS'(w);
            victim_valid_s = victim_valid_s & valid_vec_s[w];
        end
    end

    // Controller state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; flush takes priority over a request in the same cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (flushFromProc || !enableFromProc) begin
                    state_s = IDLE;
                end else if (writeFromProc) begin
                    state_s = WRITE;
                end else if (hit_any_s) begin
                    state_s = RESP;
                end else begin
                    state_s = REFILL;
                end
            end
            REFILL: begin
                if (last_beat_s) begin
                    state_s = RESP;
                end else begin
                    state_s = REFILL;
                end
            end
            WRITE: begin
                if (readyFromLl) begin
                    state_s = RESP;
                end else begin
                    state_s = WRITE;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Array write strobes: flush, victim invalidation, refill beats and write-through hits.
    always_comb begin
        flush_s   = 1'b0;
        inval_s   = {WAYS{1'b0}};
        data_we_s = {WAYS{1'b0}};
        tag_we_s  = {WAYS{1'b0}};
        wr_word_s = req_word_s;
        wr_data_s = dataFromProc;
        case (state_r)
            IDLE: begin
                flush_s = flushFromProc;
                if (req_read_s && !hit_any_s) begin
                    inval_s[victim_s] = 1'b1;
                end else begin
                    inval_s = {WAYS{1'b0}};
                end
            end
            REFILL: begin
                wr_word_s           = cnt_r;
                wr_data_s           = dataFromLl;
                data_we_s[victim_r] = readyFromLl;
                tag_we_s[victim_r]  = last_beat_s;
            end
            WRITE: begin
                data_we_s = hit_vec_s & {WAYS{readyFromLl}};
            end
            default: begin
                flush_s = 1'b0;
            end
        endcase
    end

    // Refill counter, victim latch, round-robin pointers and the read-data register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r          <= {IBITS{1'b0}};
            victim_r       <= {WBITS{1'b0}};
            victim_valid_r <= 1'b0;
            rr_r           <= {(NSETS*WBITS){1'b0}};
            data_r         <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_read_s && hit_any_s) begin
                        data_r <= hit_data_s;
                    end else if (req_read_s) begin
                        cnt_r          <= {IBITS{1'b0}};
                        victim_r       <= victim_s;
                        victim_valid_r <= victim_valid_s;
                    end
                end
                REFILL: begin
                    if (readyFromLl) begin
                        cnt_r <= cnt_r + IBITS'(1);
                        if (cnt_r == req_word_s) begin
                            data_r <= dataFromLl;
                        end
                        // Pointer only moves when a live line was displaced.
                        if (last_beat_s && victim_valid_r) begin
                            rr_r[req_set_s] <= (rr_r[req_set_s] == WBITS'(WAYS - 1)) ?
                                               {WBITS{1'b0}} : rr_r[req_set_s] + WBITS'(1);
                        end
                    end
                end
                default: begin
                    data_r <= data_r;
                end
            endcase
        end
    end

    assign dataToProc  = data_r;
    assign readyToProc = (state_r == RESP);
    assign enableToLl  = (state_r == REFILL) || (state_r == WRITE);
    assign writeToLl   = (state_r == WRITE);
    assign addrToLl    = (state_r == REFILL) ? {addrFromProc[31:2+IBITS], cnt_r, 2'b00} :
                         ((state_r == WRITE) ? addrFromProc : 32'd0);
    assign dataToLl    = (state_r == WRITE) ? dataFromProc : 32'd0;

`ifdef L1_STATS_EN
    logic [31:0] hit_cnt_r, miss_cnt_r;

    // Saturating per-request hit/miss counters; flush leaves them alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else if ((state_r == IDLE) && enableFromProc && !flushFromProc) begin
            if (hit_any_s) begin
                if (hit_cnt_r != 32'hFFFF_FFFF) begin
                    hit_cnt_r <= hit_cnt_r + 32'd1;
                end
            end else if (miss_cnt_r != 32'hFFFF_FFFF) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hitCount  = hit_cnt_r;
    assign missCount = miss_cnt_r;
`endif

endmodule

// File: tb/tb_set_assoc_l1.sv
// Self-checking bench for set_assoc_l1: directed vector table, flush and
// mid-refill reset sequences, then random traffic against a cache/memory model.
module tb_set_assoc_l1;

    localparam int WAYS  = 2;
    localparam int BSIZE = 8;
    localparam int NSETS = 256;

    logic        clock, reset;
    logic [31:0] addrFromProc, dataFromProc, dataToProc, addrToLl, dataToLl, dataFromLl;
    logic        enableFromProc, writeFromProc, flushFromProc, readyToProc;
    logic        enableToLl, writeToLl, readyFromLl;
`ifdef L1_STATS_EN
    logic [31:0] hitCount, missCount;
`endif

    set_assoc_l1 #(.WAYS(WAYS), .BSIZE(BSIZE), .NSETS(NSETS)) dut (
        .clock         (clock),
        .reset         (reset),
`ifdef L1_STATS_EN
        .hitCount      (hitCount),
        .missCount     (missCount),
`endif
        .addrFromProc  (addrFromProc),
        .enableFromProc(enableFromProc),
        .writeFromProc (writeFromProc),
        .dataFromProc  (dataFromProc),
        .flushFromProc (flushFromProc),
        .dataToProc    (dataToProc),
        .readyToProc   (readyToProc),
        .addrToLl      (addrToLl),
        .enableToLl    (enableToLl),
        .writeToLl     (writeToLl),
        .dataToLl      (dataToLl),
        .dataFromLl    (dataFromLl),
        .readyFromLl   (readyFromLl)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // LL memory: unwritten words read back as address + 0xA000_0000.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ll_addr_q [$];
    logic [31:0] ll_data_q [$];
    bit          ll_wr_q   [$];
    int          ll_delay = 1;
    int          ll_wait  = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a + 32'hA000_0000;
    endfunction

    // LL responder: waits ll_delay cycles after seeing a request, then gives one ready pulse.
    always begin
        @(posedge clock); #1;
        if (reset) begin
            readyFromLl = 1'b0;
            ll_wait     = 0;
        end else if (readyFromLl) begin
            readyFromLl = 1'b0;
            ll_wait     = 0;
        end else if (enableToLl) begin
            if (ll_wait >= ll_delay) begin
                readyFromLl = 1'b1;
                if (writeToLl) mem[addrToLl] = dataToLl;
                else dataFromLl = mem_rd(addrToLl);
                ll_addr_q.push_back(addrToLl);
                ll_wr_q.push_back(writeToLl);
                ll_data_q.push_back(writeToLl ? dataToLl : dataFromLl);
            end else begin
                ll_wait++;
            end
        end else begin
            ll_wait = 0;
        end
    end

    // Reference cache state: which blocks are resident per set, and each set's rr pointer.
    bit          mv   [NSETS][WAYS];
    logic [31:0] mtag [NSETS][WAYS];
    int          mrr  [NSETS];

    function automatic void model_reset();
        for (int s = 0; s < NSETS; s++) begin
            mrr[s] = 0;
            for (int i = 0; i < WAYS; i++) mv[s][i] = 1'b0;
        end
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < NSETS; s++)
            for (int i = 0; i < WAYS; i++) mv[s][i] = 1'b0;
    endfunction

    function automatic bit model_access(input logic [31:0] a, input bit w);
        int          s = int'((a / (BSIZE * 4)) % NSETS);
        logic [31:0] t = a / (BSIZE * 4 * NSETS);
        int          v = -1;
        for (int i = 0; i < WAYS; i++)
            if (mv[s][i] && mtag[s][i] == t) return 1'b1;
        if (w) return 1'b0;
        for (int i = 0; i < WAYS; i++)
            if (!mv[s][i] && v < 0) v = i;
        if (v < 0) begin
            v      = mrr[s];
            mrr[s] = (mrr[s] + 1) % WAYS;
        end
        mv[s][v]   = 1'b1;
        mtag[s][v] = t;
        return 1'b0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One processor request; cyc counts clock edges until readyToProc is seen.
    task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic fl,
                          output logic [31:0] rd, output int cyc, output int ops, output int first,
                          output logic done);
        first          = ll_addr_q.size();
        addrFromProc   = a;
        writeFromProc  = w;
        dataFromProc   = wd;
        flushFromProc  = fl;
        enableFromProc = 1'b1;
        cyc            = 0;
        while (!readyToProc && cyc < 300) begin
            @(posedge clock); #1;
            cyc++;
            flushFromProc = 1'b0;
        end
        done = readyToProc;
        rd   = dataToProc;
        @(posedge clock); #1;
        enableFromProc = 1'b0;
        ops  = ll_addr_q.size() - first;
    endtask

    task automatic check_access(input string nm, input logic [31:0] a, input logic w, input logic [31:0] wd,
                                input logic fl, input logic exp_hit, input logic [31:0] exp_data);
        logic [31:0] rd, base;
        int          cyc, ops, first, bad;
        logic        done;
        do_req(a, w, wd, fl, rd, cyc, ops, first, done);
        check({nm, "_ready"}, 32'(done), 32'd1);
        if (w) begin
            check({nm, "_ll_ops"}, 32'(ops), 32'd1);
            if (ops >= 1) begin
                check({nm, "_ll_wr_addr"}, ll_addr_q[first], a);
                check({nm, "_ll_wr_data"}, ll_data_q[first], wd);
                check({nm, "_ll_wr_dir"}, 32'(ll_wr_q[first]), 32'd1);
            end
        end else if (exp_hit) begin
            check({nm, "_hit_ll_ops"}, 32'(ops), 32'd0);
            check({nm, "_hit_cycles"}, 32'(cyc), fl ? 32'd2 : 32'd1);
            check({nm, "_data"}, rd, exp_data);
        end else begin
            check({nm, "_miss_ll_ops"}, 32'(ops), 32'(BSIZE));
            base = a & ~32'(BSIZE * 4 - 1);
            bad  = 0;
            for (int i = 0; i < ops && i < BSIZE; i++)
                if (ll_addr_q[first+i] !== base + 32'(4 * i) || ll_wr_q[first+i]) bad++;
            check({nm, "_refill_seq_bad"}, 32'(bad), 32'd0);
            check({nm, "_data"}, rd, exp_data);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        fl;
        logic        hit;
        logic [31:0] data;
    } vec_t;

    vec_t        tbl [14];
    int          exp_h, exp_m, st, guard;
    logic [31:0] a;
    logic        w, fl, eh;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'h0000_0104, 1'b0, 32'h0,         1'b0, 1'b0, 32'hA000_0104};
        tbl[1]  = '{32'h0000_010C, 1'b0, 32'h0,         1'b0, 1'b1, 32'hA000_010C};
        tbl[2]  = '{32'h0000_0108, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0};
        tbl[3]  = '{32'h0000_0108, 1'b0, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        tbl[4]  = '{32'h0000_9000, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{32'h0000_9000, 1'b0, 32'h0,         1'b0, 1'b0, 32'h1234_5678};
        tbl[6]  = '{32'h0000_0000, 1'b0, 32'h0,         1'b0, 1'b0, 32'hA000_0000};
        tbl[7]  = '{32'h0001_0000, 1'b0, 32'h0,         1'b0, 1'b0, 32'hA001_0000};
        tbl[8]  = '{32'h0002_0000, 1'b0, 32'h0,         1'b0, 1'b0, 32'hA002_0000};
        tbl[9]  = '{32'h0001_0000, 1'b0, 32'h0,         1'b0, 1'b1, 32'hA001_0000};
        tbl[10] = '{32'h0000_0000, 1'b0, 32'h0,         1'b0, 1'b0, 32'hA000_0000};
        tbl[11] = '{32'h0002_0000, 1'b0, 32'h0,         1'b0, 1'b1, 32'hA002_0000};
        tbl[12] = '{32'h0002_0000, 1'b0, 32'h0,         1'b1, 1'b0, 32'hA002_0000};
        tbl[13] = '{32'h0002_0000, 1'b0, 32'h0,         1'b0, 1'b1, 32'hA002_0000};

        reset          = 1'b1;
        addrFromProc   = 32'd0;
        enableFromProc = 1'b0;
        writeFromProc  = 1'b0;
        dataFromProc   = 32'd0;
        flushFromProc  = 1'b0;
        dataFromLl     = 32'd0;
        readyFromLl    = 1'b0;
        #12;
        check("rst_readyToProc", 32'(readyToProc), 32'd0);
        check("rst_enableToLl", 32'(enableToLl), 32'd0);
        check("rst_writeToLl", 32'(writeToLl), 32'd0);
        check("rst_dataToProc", dataToProc, 32'd0);
`ifdef L1_STATS_EN
        check("rst_hitCount", hitCount, 32'd0);
        check("rst_missCount", missCount, 32'd0);
`endif
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_enableToLl", 32'(enableToLl), 32'd0);

        exp_h = 0;
        exp_m = 0;
        for (int i = 0; i < 14; i++) begin
            check_access($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].wdata,
                         tbl[i].fl, tbl[i].hit, tbl[i].data);
            if (tbl[i].hit) exp_h++;
            else exp_m++;
        end
`ifdef L1_STATS_EN
        check("tbl_hitCount", hitCount, 32'(exp_h));
        check("tbl_missCount", missCount, 32'(exp_m));
`endif

        // Reset arrives after three of eight refill beats have been accepted.
        ll_delay       = 1;
        st             = ll_addr_q.size();
        addrFromProc   = 32'h0000_0104;
        writeFromProc  = 1'b0;
        enableFromProc = 1'b1;
        guard          = 0;
        while (ll_addr_q.size() < st + 3 && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        @(posedge clock); #1;
        check("midrst_beats_before", 32'(ll_addr_q.size() - st), 32'd3);
        check("midrst_enable_before", 32'(enableToLl), 32'd1);
        #2;
        reset          = 1'b1;
        enableFromProc = 1'b0;
        #1;
        check("midrst_enableToLl", 32'(enableToLl), 32'd0);
        check("midrst_readyToProc", 32'(readyToProc), 32'd0);
        check("midrst_dataToProc", dataToProc, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check_access("midrst_reread", 32'h0000_0104, 1'b0, 32'd0, 1'b0, 1'b0, mem_rd(32'h0000_0104));
        check_access("midrst_hit", 32'h0000_0110, 1'b0, 32'd0, 1'b0, 1'b1, mem_rd(32'h0000_0110));

        model_reset();
        void'(model_access(32'h0000_0104, 1'b0));
        for (int n = 0; n < 250; n++) begin
            a        = (32'($urandom_range(0, 3)) << 13) | (32'($urandom_range(0, 3)) << 5) |
                       (32'($urandom_range(0, BSIZE - 1)) << 2);
            w        = ($urandom_range(0, 3) == 0);
            fl       = ($urandom_range(0, 15) == 0);
            ll_delay = int'($urandom_range(0, 2));
            if (fl) model_flush();
            eh = model_access(a, w);
            check_access($sformatf("rnd%0d", n), a, w, $urandom, fl, eh, mem_rd(a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
